rename_map_table: RTL and testbench
===================================

# rename_map_table

- Single-issue register rename stage; sits directly upstream of the free list.
- Holds the architectural-to-physical map and translates one instruction's sources and destination per request.
- For a destination, requests a new physical register from the free list over its dequeue handshake, and retries until one is granted.
- Forwards committed old physical registers back to the free list's enqueue port.

## Interface
- NUM_ARCH_REGS, 32, architectural registers; power of two.
- NUM_PHYS_REGS, 64, physical registers; > NUM_ARCH_REGS.
- LOG_ARCH, $clog2(NUM_ARCH_REGS), arch index width.
- LOG_PHYS, $clog2(NUM_PHYS_REGS), phys index width.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-low reset.
- Rename_IN  in  1  rename request, valid when Ready_OUT=1.
- Src1Arch_IN, Src2Arch_IN  in  LOG_ARCH  source arch registers.
- DestValid_IN  in  1  instruction writes a destination.
- DestArch_IN  in  LOG_ARCH  destination arch register.
- Ready_OUT  out  1  block can accept a request this cycle.
- Done_OUT  out  1  one-cycle pulse; result outputs valid.
- Src1Phys_OUT, Src2Phys_OUT  out  LOG_PHYS  translated sources.
- DestPhys_OUT  out  LOG_PHYS  newly allocated phys reg; 0 when no destination.
- OldDestPhys_OUT  out  LOG_PHYS  previous mapping of DestArch; 0 when no destination.
- FreeDequeue_OUT  out  1  dequeue request to free list.
- FreeDequeueResult_IN  in  1  free list grant; registered by free list.
- FreeData_IN  in  LOG_PHYS  granted phys reg.
- Commit_IN  in  1  instruction retiring with a destination.
- CommitOldPhys_IN  in  LOG_PHYS  old phys reg to release.
- FreeEnqueue_OUT  out  1  enqueue request to free list.
- FreeEnqData_OUT  out  LOG_PHYS  register being released.
- StallCount_OUT  out  16  saturating count of failed allocation attempts.

## Operation
- Map table: NUM_ARCH_REGS entries of LOG_PHYS bits.
  - Reset value: entry i = i.
  - System requirement: the free list initially holds NUM_ARCH_REGS..NUM_PHYS_REGS-1.
- FSM states and transitions:
  - IDLE: Ready_OUT=1. On Rename_IN:
    - latch both source mappings from the current map, and latch DestArch;
    - if DestValid_IN, go to ALLOC; otherwise go to DONE with DestPhys/OldDestPhys = 0.
  - ALLOC: FreeDequeue_OUT=1 for exactly this cycle. Go to CHECK.
  - CHECK: sample FreeDequeueResult_IN.
    - 1: OldDestPhys <= map[DestArch]; map[DestArch] <= FreeData_IN; DestPhys <= FreeData_IN; go to DONE.
    - 0: StallCount_OUT += 1 (saturate at 16'hFFFF); go to ALLOC.
  - DONE: Done_OUT=1; go to IDLE.
- Source/destination aliasing: a source equal to DestArch gets the pre-rename mapping, because sources are latched in IDLE.
- Commit path is independent of the FSM.
  - Commit_IN in cycle n gives FreeEnqueue_OUT=1 with FreeEnqData_OUT=CommitOldPhys_IN in cycle n+1 (registered).
  - Otherwise FreeEnqueue_OUT=0.
- Result outputs hold their values until the next DONE.

## Timing
- All outputs and state are registered.
  - Exception: Ready_OUT and FreeDequeue_OUT, which are decoded directly from the state.
- Latency, accept cycle = 0:
  - no destination: Done_OUT in cycle 1;
  - destination, first grant succeeds: ALLOC in cycle 1, CHECK in cycle 2, Done_OUT in cycle 3;
  - each failed attempt adds 2 cycles.
- Throughput:
  - no-destination instructions: one per 2 cycles;
  - destination instructions: one per 4 cycles.
- Map write takes effect at the CHECK→DONE edge, so the next accepted request sees it.
- Commit and rename may occur in the same cycle; there is no interaction.
- Reset, asynchronous and effective mid-operation:
  - state returns to IDLE and the map returns to identity;
  - all outputs go to 0 except Ready_OUT=1, including StallCount_OUT=0;
  - a pending commit enqueue is dropped.

## Test plan
- Reset, then Rename with Src1=3, Src2=5, DestValid=0:
  - Done in cycle 1;
  - Src1Phys=3, Src2Phys=5, DestPhys=0;
  - Ready low only during cycle 1.
- Rename Dest=4, Src1=4; free list grants 32:
  - Done in cycle 3 with Src1Phys=4, DestPhys=32, OldDestPhys=4.
  - A following Rename with Src1=4 returns Src1Phys=32.
- Free list empty for 3 attempts, then grants 40:
  - FreeDequeue pulses in cycles 1, 3, 5, 7;
  - Done in cycle 9 with DestPhys=40;
  - StallCount_OUT=3.
- Commit_IN with CommitOldPhys=4, concurrent with a Rename in CHECK:
  - FreeEnqueue=1 and FreeEnqData=4 the next cycle;
  - the rename completes unaffected.
- Assert RESET low during CHECK after a grant of 33:
  - immediately Ready=1 and Done=0;
  - the map entry is not updated (a Rename of Src1=Dest reads identity).
- Rename Dest=7 twice, with grants 32 then 33:
  - second result has OldDestPhys=32, DestPhys=33.

Source files
------------

// File: rtl/rename_map_table_if.sv
// Signal bundle between the rename stage, its instruction source and the free list.
// The slave modport is the rename block's view; the master modport is the surrounding pipeline's view.
interface rename_map_table_if #(
    parameter int LOG_ARCH = 5,
    parameter int LOG_PHYS = 6
);
    logic                Rename_IN;
    logic [LOG_ARCH-1:0] Src1Arch_IN;
    logic [LOG_ARCH-1:0] Src2Arch_IN;
    logic                DestValid_IN;
    logic [LOG_ARCH-1:0] DestArch_IN;
    logic                Ready_OUT;
    logic                Done_OUT;
    logic [LOG_PHYS-1:0] Src1Phys_OUT;
    logic [LOG_PHYS-1:0] Src2Phys_OUT;
    logic [LOG_PHYS-1:0] DestPhys_OUT;
    logic [LOG_PHYS-1:0] OldDestPhys_OUT;
    logic                FreeDequeue_OUT;
    logic                FreeDequeueResult_IN;
    logic [LOG_PHYS-1:0] FreeData_IN;
    logic                Commit_IN;
    logic [LOG_PHYS-1:0] CommitOldPhys_IN;
    logic                FreeEnqueue_OUT;
    logic [LOG_PHYS-1:0] FreeEnqData_OUT;
    logic [15:0]         StallCount_OUT;

    modport slave (
        input  Rename_IN, Src1Arch_IN, Src2Arch_IN, DestValid_IN, DestArch_IN,
        input  FreeDequeueResult_IN, FreeData_IN, Commit_IN, CommitOldPhys_IN,
        output Ready_OUT, Done_OUT, Src1Phys_OUT, Src2Phys_OUT, DestPhys_OUT,
        output OldDestPhys_OUT, FreeDequeue_OUT, FreeEnqueue_OUT, FreeEnqData_OUT,
        output StallCount_OUT
    );

    modport master (
        output Rename_IN, Src1Arch_IN, Src2Arch_IN, DestValid_IN, DestArch_IN,
        output FreeDequeueResult_IN, FreeData_IN, Commit_IN, CommitOldPhys_IN,
        input  Ready_OUT, Done_OUT, Src1Phys_OUT, Src2Phys_OUT, DestPhys_OUT,
        input  OldDestPhys_OUT, FreeDequeue_OUT, FreeEnqueue_OUT, FreeEnqData_OUT,
        input  StallCount_OUT
    );
endinterface

// File: rtl/rename_map_table.sv
// Single-issue register rename: architectural-to-physical map, destination allocation
// from the free list with retry, and a registered commit path back to the free list.
module rename_map_table #(
    parameter int NUM_ARCH_REGS = 32,
    parameter int NUM_PHYS_REGS = 64,
    parameter int LOG_ARCH      = $clog2(NUM_ARCH_REGS),
    parameter int LOG_PHYS      = $clog2(NUM_PHYS_REGS)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    rename_map_table_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [LOG_PHYS-1:0] phys_t;
    typedef logic [LOG_ARCH-1:0] arch_t;

    state_e      state_q, state_d;
    phys_t       map_q [NUM_ARCH_REGS];
    phys_t       map_d [NUM_ARCH_REGS];

    // Source mappings captured at accept time, so a source aliasing the destination
    // sees the pre-rename mapping even though the map is written before DONE.
    phys_t       src1_lat_q, src1_lat_d;
    phys_t       src2_lat_q, src2_lat_d;
    arch_t       dest_arch_q, dest_arch_d;

    phys_t       src1_out_q, src1_out_d;
    phys_t       src2_out_q, src2_out_d;
    phys_t       dest_phys_q, dest_phys_d;
    phys_t       old_dest_q, old_dest_d;
    logic        done_q, done_d;
    logic [15:0] stall_q, stall_d;
    logic        enq_q, enq_d;
    phys_t       enq_data_q, enq_data_d;

    // NOTE: every variable gets a default before the case statement so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        src1_lat_d  = src1_lat_q;
        src2_lat_d  = src2_lat_q;
        dest_arch_d = dest_arch_q;
        src1_out_d  = src1_out_q;
        src2_out_d  = src2_out_q;
        dest_phys_d = dest_phys_q;
        old_dest_d  = old_dest_q;
        done_d      = 1'b0;
        stall_d     = stall_q;

        case (state_q)
            IDLE: begin
                if (bus.Rename_IN) begin
                    src1_lat_d  = map_q[bus.Src1Arch_IN];
                    src2_lat_d  = map_q[bus.Src2Arch_IN];
                    dest_arch_d = bus.DestArch_IN;
                    if (bus.DestValid_IN) begin
                        state_d = ALLOC;
                    end else begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        src1_out_d  = map_q[bus.Src1Arch_IN];
                        src2_out_d  = map_q[bus.Src2Arch_IN];
                        dest_phys_d = '0;
                        old_dest_d  = '0;
                    end
                end
            end
            ALLOC: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (bus.FreeDequeueResult_IN) begin
                    old_dest_d         = map_q[dest_arch_q];
                    map_d[dest_arch_q] = bus.FreeData_IN;
                    dest_phys_d        = bus.FreeData_IN;
                    src1_out_d         = src1_lat_q;
                    src2_out_d         = src2_lat_q;
                    done_d             = 1'b1;
                    state_d            = DONE;
                end else begin
                    if (stall_q != 16'hFFFF) begin
                        stall_d = stall_q + 16'd1;
                    end
                    state_d = ALLOC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Commit release is a plain one-cycle register stage, independent of the rename FSM.
    always_comb begin
        enq_d      = bus.Commit_IN;
        enq_data_d = bus.Commit_IN ? bus.CommitOldPhys_IN : enq_data_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            // NOTE: the map is reset entry-by-entry to identity, so it is built from
            // flops rather than a RAM macro; software relies on the identity start state.
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_q[i] <= phys_t'(i);
            end
            src1_lat_q  <= '0;
            src2_lat_q  <= '0;
            dest_arch_q <= '0;
            src1_out_q  <= '0;
            src2_out_q  <= '0;
            dest_phys_q <= '0;
            old_dest_q  <= '0;
            done_q      <= 1'b0;
            stall_q     <= '0;
            enq_q       <= 1'b0;
            enq_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            src1_lat_q  <= src1_lat_d;
            src2_lat_q  <= src2_lat_d;
            dest_arch_q <= dest_arch_d;
            src1_out_q  <= src1_out_d;
            src2_out_q  <= src2_out_d;
            dest_phys_q <= dest_phys_d;
            old_dest_q  <= old_dest_d;
            done_q      <= done_d;
            stall_q     <= stall_d;
            enq_q       <= enq_d;
            enq_data_q  <= enq_data_d;
        end
    end

    assign bus.Ready_OUT       = (state_q == IDLE);
    assign bus.FreeDequeue_OUT = (state_q == ALLOC);
    assign bus.Done_OUT        = done_q;
    assign bus.Src1Phys_OUT    = src1_out_q;
    assign bus.Src2Phys_OUT    = src2_out_q;
    assign bus.DestPhys_OUT    = dest_phys_q;
    assign bus.OldDestPhys_OUT = old_dest_q;
    assign bus.StallCount_OUT  = stall_q;
    assign bus.FreeEnqueue_OUT = enq_q;
    assign bus.FreeEnqData_OUT = enq_data_q;

    // Done must be a single-cycle pulse and must coincide with the DONE state.
    a_done_pulse: assert property (@(posedge CLK) disable iff (!RESET)
        bus.Done_OUT |=> !bus.Done_OUT);
    a_done_state: assert property (@(posedge CLK) disable iff (!RESET)
        bus.Done_OUT == (state_q == DONE));

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: scoreboarded rename results, a behavioural
// free list with programmable denials, commit forwarding and asynchronous reset.
module tb_rename_map_table;

    localparam int LA = 5;
    localparam int LP = 6;
    localparam int NA = 32;

    typedef struct packed {
        logic [LP-1:0] src1;
        logic [LP-1:0] src2;
        logic [LP-1:0] dest;
        logic [LP-1:0] old;
    } res_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    rename_map_table_if #(.LOG_ARCH(LA), .LOG_PHYS(LP)) bus ();

    rename_map_table #(.NUM_ARCH_REGS(32), .NUM_PHYS_REGS(64)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference model and scoreboard
    logic [LP-1:0] exp_map [NA];
    res_t          exp_q [$];
    int            exp_stall;

    // Free list model: deny a number of attempts, then grant the next queued register
    int            deny_left;
    logic [LP-1:0] grant_q [$];
    logic          deq_prev;

    // Observations collected by the driver
    int            deq_cyc_q [$];
    int            ready_low;
    logic          ready_at_issue;
    logic          enq_seen;
    logic [LP-1:0] enq_data_seen;
    logic          rst_ready, rst_done;
    logic [15:0]   rst_stall;

    always @(negedge CLK) begin
        if (!RESET) begin
            deq_prev                 = 1'b0;
            bus.FreeDequeueResult_IN = 1'b0;
            bus.FreeData_IN          = '0;
        end else begin
            bus.FreeDequeueResult_IN = 1'b0;
            if (deq_prev) begin
                if (deny_left > 0) begin
                    deny_left = deny_left - 1;
                end else if (grant_q.size() > 0) begin
                    bus.FreeDequeueResult_IN = 1'b1;
                    bus.FreeData_IN          = grant_q.pop_front();
                end
            end
            deq_prev = bus.FreeDequeue_OUT;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        for (int i = 0; i < NA; i++) exp_map[i] = LP'(i);
        exp_q.delete();
        grant_q.delete();
        deny_left = 0;
        exp_stall = 0;
    endtask

    // Issues one rename, pushes the expected result, then follows it cycle by cycle
    // (cycle 0 = accept cycle) until Done, an optional mid-flight reset, or a timeout.
    task automatic run_rename(input logic [LA-1:0] s1, input logic [LA-1:0] s2,
                              input logic dv, input logic [LA-1:0] d,
                              input int denials, input logic [LP-1:0] grant,
                              input int commit_cyc, input logic [LP-1:0] commit_data,
                              input int reset_cyc,
                              output res_t obs, output int done_cyc);
        res_t e;
        e.src1 = exp_map[s1];
        e.src2 = exp_map[s2];
        if (dv) begin
            e.old      = exp_map[d];
            e.dest     = grant;
            exp_map[d] = grant;
            deny_left  = denials;
            grant_q.push_back(grant);
            exp_stall  = exp_stall + denials;
        end else begin
            e.old  = '0;
            e.dest = '0;
        end
        exp_q.push_back(e);

        deq_cyc_q.delete();
        ready_low = 0;
        done_cyc  = -1;
        obs       = '0;
        enq_seen  = 1'b0;

        @(negedge CLK);
        ready_at_issue   = bus.Ready_OUT;
        bus.Rename_IN    = 1'b1;
        bus.Src1Arch_IN  = s1;
        bus.Src2Arch_IN  = s2;
        bus.DestValid_IN = dv;
        bus.DestArch_IN  = d;

        for (int c = 1; c <= 60; c++) begin
            @(negedge CLK);
            if (c == 1) bus.Rename_IN = 1'b0;
            if (!bus.Ready_OUT) ready_low++;
            if (bus.FreeDequeue_OUT) deq_cyc_q.push_back(c);
            if (c == commit_cyc + 1) begin
                enq_seen      = bus.FreeEnqueue_OUT;
                enq_data_seen = bus.FreeEnqData_OUT;
                bus.Commit_IN = 1'b0;
            end
            if (c == commit_cyc) begin
                bus.Commit_IN        = 1'b1;
                bus.CommitOldPhys_IN = commit_data;
            end
            if (c == reset_cyc) begin
                RESET = 1'b0;
                #1;
                rst_ready = bus.Ready_OUT;
                rst_done  = bus.Done_OUT;
                rst_stall = bus.StallCount_OUT;
                return;
            end
            if (bus.Done_OUT) begin
                done_cyc = c;
                obs      = {bus.Src1Phys_OUT, bus.Src2Phys_OUT, bus.DestPhys_OUT, bus.OldDestPhys_OUT};
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET                = 1'b0;
        bus.Rename_IN        = 1'b0;
        bus.Src1Arch_IN      = '0;
        bus.Src2Arch_IN      = '0;
        bus.DestValid_IN     = 1'b0;
        bus.DestArch_IN      = '0;
        bus.Commit_IN        = 1'b0;
        bus.CommitOldPhys_IN = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        n_checks++;
        if (bus.Ready_OUT !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.Ready_OUT);
        end
        n_checks++;
        if ({bus.Done_OUT, bus.FreeDequeue_OUT, bus.FreeEnqueue_OUT} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: done/deq/enq got %b expected 000",
                               {bus.Done_OUT, bus.FreeDequeue_OUT, bus.FreeEnqueue_OUT});
        end
        n_checks++;
        if (bus.StallCount_OUT !== 16'd0) begin
            n_fail++; $display("FAIL reset_stall: got %0d expected 0", bus.StallCount_OUT);
        end
        n_checks++;
        if ({bus.Src1Phys_OUT, bus.Src2Phys_OUT, bus.DestPhys_OUT, bus.OldDestPhys_OUT} !== '0) begin
            n_fail++; $display("FAIL reset_results: got %h expected 0",
                               {bus.Src1Phys_OUT, bus.Src2Phys_OUT, bus.DestPhys_OUT, bus.OldDestPhys_OUT});
        end
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_no_dest();
        res_t obs, e;
        int   dc;
        run_rename(5'd3, 5'd5, 1'b0, 5'd0, 0, '0, -10, '0, -1, obs, dc);
        n_checks++;
        if (ready_at_issue !== 1'b1) begin
            n_fail++; $display("FAIL nodest_ready_accept: got %b expected 1", ready_at_issue);
        end
        n_checks++;
        if (dc !== 1) begin
            n_fail++; $display("FAIL nodest_latency: done cycle %0d expected 1", dc);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL nodest_result: got %h expected %h", obs, e);
        end
        n_checks++;
        if (ready_low !== 1) begin
            n_fail++; $display("FAIL nodest_ready_low: low cycles %0d expected 1", ready_low);
        end
        @(negedge CLK);
        n_checks++;
        if (bus.Ready_OUT !== 1'b1) begin
            n_fail++; $display("FAIL nodest_ready_after: got %b expected 1", bus.Ready_OUT);
        end
    endtask

    task automatic test_dest_alias();
        res_t obs, e;
        int   dc;
        run_rename(5'd4, 5'd0, 1'b1, 5'd4, 0, 6'd32, -10, '0, -1, obs, dc);
        n_checks++;
        if (dc !== 3) begin
            n_fail++; $display("FAIL alias_latency: done cycle %0d expected 3", dc);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL alias_result: got %h expected %h", obs, e);
        end
        n_checks++;
        if (deq_cyc_q.size() !== 1 || deq_cyc_q[0] !== 1) begin
            n_fail++; $display("FAIL alias_dequeue: %0d pulses, first at %0d, expected 1 pulse at 1",
                               deq_cyc_q.size(), (deq_cyc_q.size() > 0) ? deq_cyc_q[0] : -1);
        end
        run_rename(5'd4, 5'd4, 1'b0, 5'd0, 0, '0, -10, '0, -1, obs, dc);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL alias_followup: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_stall();
        res_t obs, e;
        int   dc;
        int   exp_deq [4] = '{1, 3, 5, 7};
        logic deq_ok;
        run_rename(5'd10, 5'd11, 1'b1, 5'd10, 3, 6'd40, -10, '0, -1, obs, dc);
        deq_ok = (deq_cyc_q.size() == 4);
        for (int i = 0; i < 4 && deq_ok; i++) deq_ok = (deq_cyc_q[i] == exp_deq[i]);
        n_checks++;
        if (!deq_ok) begin
            n_fail++; $display("FAIL stall_dequeue_cycles: %0d pulses, expected cycles 1,3,5,7",
                               deq_cyc_q.size());
        end
        n_checks++;
        if (dc !== 9) begin
            n_fail++; $display("FAIL stall_latency: done cycle %0d expected 9", dc);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL stall_result: got %h expected %h", obs, e);
        end
        n_checks++;
        if (bus.StallCount_OUT !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL stall_count: got %0d expected %0d", bus.StallCount_OUT, exp_stall);
        end
    endtask

    task automatic test_commit();
        res_t obs, e;
        int   dc;
        run_rename(5'd12, 5'd10, 1'b1, 5'd12, 0, 6'd41, 2, 6'd4, -1, obs, dc);
        n_checks++;
        if (enq_seen !== 1'b1 || enq_data_seen !== 6'd4) begin
            n_fail++; $display("FAIL commit_enqueue: enq %b data %0d expected 1 and 4", enq_seen, enq_data_seen);
        end
        n_checks++;
        if (dc !== 3) begin
            n_fail++; $display("FAIL commit_latency: done cycle %0d expected 3", dc);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL commit_result: got %h expected %h", obs, e);
        end
        @(negedge CLK);
        n_checks++;
        if (bus.FreeEnqueue_OUT !== 1'b0) begin
            n_fail++; $display("FAIL commit_enqueue_drop: got %b expected 0", bus.FreeEnqueue_OUT);
        end
    endtask

    task automatic test_reset_mid();
        res_t obs, e;
        int   dc;
        run_rename(5'd6, 5'd1, 1'b1, 5'd6, 0, 6'd33, -10, '0, 2, obs, dc);
        n_checks++;
        if (rst_ready !== 1'b1 || rst_done !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs: ready %b done %b expected 1 and 0", rst_ready, rst_done);
        end
        n_checks++;
        if (rst_stall !== 16'd0) begin
            n_fail++; $display("FAIL midreset_stall: got %0d expected 0", rst_stall);
        end
        n_checks++;
        if (dc !== -1) begin
            n_fail++; $display("FAIL midreset_no_done: done cycle %0d expected none", dc);
        end
        model_reset();
        bus.Commit_IN = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        run_rename(5'd6, 5'd7, 1'b0, 5'd0, 0, '0, -10, '0, -1, obs, dc);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++; $display("FAIL midreset_identity: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        res_t obs, e;
        int   dc;
        run_rename(5'd7, 5'd2, 1'b1, 5'd7, 0, 6'd32, -10, '0, -1, obs, dc);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || dc !== 3) begin
            n_fail++; $display("FAIL b2b_first: got %h at cycle %0d expected %h at 3", obs, dc, e);
        end
        run_rename(5'd7, 5'd7, 1'b1, 5'd7, 0, 6'd33, -10, '0, -1, obs, dc);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || dc !== 3) begin
            n_fail++; $display("FAIL b2b_second: got %h at cycle %0d expected %h at 3", obs, dc, e);
        end
        n_checks++;
        if (ready_at_issue !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b expected 1", ready_at_issue);
        end
    endtask

    initial begin
        test_reset();
        test_no_dest();
        test_dest_alias();
        test_stall();
        test_commit();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
